// File: rtl/stream_demux_1ton_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
package stream_demux_1ton_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Minimum select width able to address n channels (at least 1 bit).
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << (i - 1)) < n) begin
                w = i;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_demux_1ton_slot.sv
// One-entry valid/ready holding register; refills in the same cycle it drains.
module stream_demux_1ton_slot #(
    parameter int unsigned DataW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DataW-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [DataW-1:0] data_o,
    output logic             free_o
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = ~valid_q | ready_i;

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demux with explicit-select and round-robin routing.
module stream_demux_1ton
    import stream_demux_1ton_pkg::*;
#(
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    mode,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [SEL_W-1:0]        rr_ptr,
    output logic                    drop_pulse
);

    if (N_OUT < 2 || SEL_W < sel_width(N_OUT)) begin : gen_param_err
        $error("stream_demux_1ton: SEL_W too narrow for N_OUT or N_OUT < 2");
    end

    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [N_OUT-1:0] hit, slot_free, load;
    logic             legal, accept;
    logic             drop_q, drop_d;

    // A target outside 0..N_OUT-1 matches no slot, so in_ready stays 1 and the beat is dropped.
    always_comb begin
        tgt      = (mode == MODE_RR) ? rr_ptr_q : in_sel;
        hit      = '0;
        in_ready = 1'b1;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (tgt == SEL_W'(k)) begin
                hit[k]   = 1'b1;
                in_ready = slot_free[k];
            end
        end
        legal    = |hit;
        accept   = in_valid & in_ready;
        load     = {N_OUT{accept}} & hit;
        drop_d   = accept & ~legal;
        rr_ptr_d = rr_ptr_q;
        if (accept && mode == MODE_RR) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            drop_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : gen_slot
        stream_demux_1ton_slot #(
            .DataW(DATA_W)
        ) u_slot (
            .clk_i  (clk),
            .rst_ni (rst_n),
            .load_i (load[k]),
            .data_i (in_data),
            .ready_i(out_ready[k]),
            .valid_o(out_valid[k]),
            .data_o (out_data[k*DATA_W +: DATA_W]),
            .free_o (slot_free[k])
        );
    end

    assign rr_ptr     = rr_ptr_q;
    assign drop_pulse = drop_q;

endmodule
